// File: rtl/hi_lo_muldiv_unit_pkg.sv
// Shared funct encodings and FSM state type for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} muldiv_state_t;

endpackage

// File: rtl/hi_lo_muldiv_unit_if.sv
// Execute-stage request bus into the HI/LO unit and its result/stall outputs.
interface hi_lo_muldiv_unit_if #(parameter int WIDTH = 32);

  logic             using_HI_LO_execute;
  logic [5:0]       ALU_function_execute;
  logic             HI_register_write_execute;
  logic             LO_register_write_execute;
  logic [WIDTH-1:0] src_A_execute;
  logic [WIDTH-1:0] src_B_execute;
  logic [WIDTH-1:0] HI_out;
  logic [WIDTH-1:0] LO_out;
  logic             busy;
  logic             stall_muldiv;

  modport master (
    output using_HI_LO_execute, ALU_function_execute,
           HI_register_write_execute, LO_register_write_execute,
           src_A_execute, src_B_execute,
    input  HI_out, LO_out, busy, stall_muldiv
  );

  modport slave (
    input  using_HI_LO_execute, ALU_function_execute,
           HI_register_write_execute, LO_register_write_execute,
           src_A_execute, src_B_execute,
    output HI_out, LO_out, busy, stall_muldiv
  );

endinterface

// File: rtl/hi_lo_muldiv_unit_iter_datapath.sv
// One-bit-per-cycle shift-add multiply / restoring divide over a shared 2*WIDTH accumulator.
module muldiv_iter_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step_mul,
  input  logic               step_div,
  input  logic [2*WIDTH-1:0] load_acc,
  input  logic [WIDTH-1:0]   load_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;

  // Upper half is the running partial product / remainder, lower half the multiplier / quotient.
  always_comb begin
    acc_d    = acc_q;
    opb_d    = opb_q;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    if (load) begin
      acc_d = load_acc;
      opb_d = load_b;
    end else if (step_mul) begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (step_div) begin
      acc_d = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                              : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// Owns HI/LO; sequences iterative MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO.
//   state | meaning
//   IDLE  | accept requests, MTHI/MTLO write immediately
//   MUL   | WIDTH shift-add steps
//   DIV   | WIDTH restoring steps (skipped on divide by zero)
//   FIX   | apply signs, write HI/LO
module hi_lo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic                clk,
  input logic                reset,
  hi_lo_muldiv_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             is_div_q, is_div_d, zero_q, zero_d;
  logic             prod_neg_q, prod_neg_d, quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

  logic [5:0]         funct;
  logic [WIDTH-1:0]   src_a, src_b, abs_a, abs_b;
  logic               req_valid, is_signed, is_mul_op, is_div_op, sign_a, sign_b, div_by_zero;
  logic               load, step_mul, step_div;
  logic [2*WIDTH-1:0] load_acc, acc, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign funct       = bus.ALU_function_execute;
  assign src_a       = bus.src_A_execute;
  assign src_b       = bus.src_B_execute;
  assign req_valid   = bus.using_HI_LO_execute &
                       (bus.HI_register_write_execute | bus.LO_register_write_execute);
  assign is_mul_op   = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign is_div_op   = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign is_signed   = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign sign_a      = is_signed & src_a[WIDTH-1];
  assign sign_b      = is_signed & src_b[WIDTH-1];
  assign abs_a       = sign_a ? (~src_a + 1'b1) : src_a;
  assign abs_b       = sign_b ? (~src_b + 1'b1) : src_b;
  assign div_by_zero = (src_b == '0);

  assign load     = (state_q == IDLE) && req_valid && (is_mul_op || is_div_op);
  // Divide by zero preloads the raw dividend and all-ones so FIX writes them unchanged.
  assign load_acc = (is_div_op && div_by_zero) ? {src_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, abs_a};
  assign step_mul = (state_q == MUL);
  assign step_div = (state_q == DIV) && !zero_q;

  muldiv_iter_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step_mul (step_mul),
    .step_div (step_div),
    .load_acc (load_acc),
    .load_b   (abs_b),
    .acc      (acc)
  );

  assign prod = prod_neg_q ? (~acc + 1'b1) : acc;
  assign quo  = quo_neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem  = rem_neg_q ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    zero_d     = zero_q;
    prod_neg_d = prod_neg_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (funct == FUNCT_MTHI) begin
            hi_d = src_a;
          end else if (funct == FUNCT_MTLO) begin
            lo_d = src_a;
          end else if (is_mul_op) begin
            state_d    = MUL;
            counter_d  = '0;
            is_div_d   = 1'b0;
            zero_d     = 1'b0;
            prod_neg_d = sign_a ^ sign_b;
          end else if (is_div_op) begin
            state_d   = DIV;
            counter_d = '0;
            is_div_d  = 1'b1;
            zero_d    = div_by_zero;
            quo_neg_d = !div_by_zero && (sign_a ^ sign_b);
            rem_neg_d = !div_by_zero && sign_a;
          end
        end
      end
      MUL, DIV: begin
        counter_d = counter_q + 1'b1;
        if ((state_q == DIV && zero_q) || counter_q == LAST) begin
          state_d   = FIX;
          counter_d = '0;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (is_div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      is_div_q   <= 1'b0;
      zero_q     <= 1'b0;
      prod_neg_q <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      is_div_q   <= is_div_d;
      zero_q     <= zero_d;
      prod_neg_q <= prod_neg_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
    end
  end

  assign bus.HI_out       = hi_q;
  assign bus.LO_out       = lo_q;
  assign bus.busy         = busy_q;
  assign bus.stall_muldiv = busy_q & bus.using_HI_LO_execute;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Directed bench for hi_lo_muldiv_unit: arithmetic model feeds a scoreboard queue, popped when busy drops.
module tb_hi_lo_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hi_lo_muldiv_unit_if #(.WIDTH(W)) bus ();

  hi_lo_muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      FUNCT_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        return u;
      end
      FUNCT_MULT: begin
        q = sa * sb;
        return q;
      end
      FUNCT_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      FUNCT_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      FUNCT_MTHI: return {a, m_lo};
      FUNCT_MTLO: return {m_hi, a};
      default:    return {m_hi, m_lo};
    endcase
  endfunction

  task automatic idle_bus();
    bus.using_HI_LO_execute       = 1'b0;
    bus.ALU_function_execute      = 6'h00;
    bus.HI_register_write_execute = 1'b0;
    bus.LO_register_write_execute = 1'b0;
    bus.src_A_execute             = '0;
    bus.src_B_execute             = '0;
  endtask

  task automatic drive_req(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.using_HI_LO_execute       = 1'b1;
    bus.ALU_function_execute      = f;
    bus.HI_register_write_execute = (f != FUNCT_MTLO);
    bus.LO_register_write_execute = (f != FUNCT_MTHI);
    bus.src_A_execute             = a;
    bus.src_B_execute             = b;
  endtask

  task automatic push_exp(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = model(f, a, b);
    sb_q.push_back('{tag, e[63:32], e[31:0]});
  endtask

  task automatic pop_and_check();
    exp_t x;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd1);
      return;
    end
    x = sb_q.pop_front();
    chk({x.tag, "_HI"}, 64'(bus.HI_out), 64'(x.hi));
    chk({x.tag, "_LO"}, 64'(bus.LO_out), 64'(x.lo));
    m_hi = x.hi;
    m_lo = x.lo;
  endtask

  // Called at a negedge; returns at the negedge where busy has fallen.
  task automatic run_long(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy);
    int   cnt;
    logic moved;
    logic [31:0] old_hi, old_lo;
    push_exp(tag, f, a, b);
    old_hi = bus.HI_out;
    old_lo = bus.LO_out;
    drive_req(f, a, b);
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    cnt   = 0;
    moved = 1'b0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      if (bus.HI_out !== old_hi || bus.LO_out !== old_lo) moved = 1'b1;
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(exp_busy));
    chk({tag, "_hilo_held"}, 64'(moved), 64'd0);
    pop_and_check();
  endtask

  initial begin
    int          cnt;
    logic        stall_ok, lo_held;
    logic [31:0] old_lo;

    idle_bus();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_HI", 64'(bus.HI_out), 64'd0);
    chk("reset_LO", 64'(bus.LO_out), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_long("multu_max_x2",   FUNCT_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 33);
    run_long("mult_neg3_x7",   FUNCT_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 33);
    run_long("mult_min_x_min", FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 33);
    run_long("div_neg7_2",     FUNCT_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 33);
    run_long("divu_7_0",       FUNCT_DIVU,  32'h0000_0007, 32'h0000_0000, 2);
    run_long("div_neg5_0",     FUNCT_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 2);
    run_long("div_min_neg1",   FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33);
    run_long("div_7_neg2",     FUNCT_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 33);
    run_long("divu_big",       FUNCT_DIVU,  32'hDEAD_BEEF, 32'h0000_1234, 33);
    run_long("multu_rand",     FUNCT_MULTU, 32'h9E37_79B9, 32'h7F4A_7C15, 33);

    // MTHI then MTLO on back-to-back cycles
    push_exp("mthi", FUNCT_MTHI, 32'h1234_5678, 32'h0);
    drive_req(FUNCT_MTHI, 32'h1234_5678, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_stall", 64'(bus.stall_muldiv), 64'd0);
    pop_and_check();
    push_exp("mtlo", FUNCT_MTLO, 32'h9ABC_DEF0, 32'h0);
    drive_req(FUNCT_MTLO, 32'h9ABC_DEF0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    chk("mtlo_stall", 64'(bus.stall_muldiv), 64'd0);
    pop_and_check();
    idle_bus();
    @(negedge clk);

    // MULT with an MFLO held in execute behind it
    push_exp("mult_mflo", FUNCT_MULT, 32'h0001_0003, 32'hFFFF_0005);
    old_lo = bus.LO_out;
    drive_req(FUNCT_MULT, 32'h0001_0003, 32'hFFFF_0005);
    @(posedge clk);
    @(negedge clk);
    bus.ALU_function_execute      = FUNCT_MFLO;
    bus.HI_register_write_execute = 1'b0;
    bus.LO_register_write_execute = 1'b0;
    bus.src_A_execute             = 32'h5555_AAAA;
    bus.src_B_execute             = 32'h0;
    cnt      = 0;
    stall_ok = 1'b1;
    lo_held  = 1'b1;
    while (bus.busy === 1'b1 && cnt < 100) begin
      if (bus.stall_muldiv !== 1'b1) stall_ok = 1'b0;
      if (bus.LO_out !== old_lo) lo_held = 1'b0;
      cnt++;
      @(negedge clk);
    end
    chk("mflo_stall_while_busy", 64'(stall_ok), 64'd1);
    chk("mflo_lo_held", 64'(lo_held), 64'd1);
    chk("mflo_busy_cycles", 64'(cnt), 64'd33);
    chk("mflo_stall_released", 64'(bus.stall_muldiv), 64'd0);
    pop_and_check();
    @(negedge clk);
    chk("mflo_no_side_effect_LO", 64'(bus.LO_out), 64'(m_lo));
    idle_bus();
    @(negedge clk);

    // Asynchronous reset in the middle of a divide
    drive_req(FUNCT_DIV, 32'h7654_3210, 32'h0000_0013);
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    repeat (9) @(negedge clk);
    chk("abort_busy_before_reset", 64'(bus.busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_HI", 64'(bus.HI_out), 64'd0);
    chk("abort_LO", 64'(bus.LO_out), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_exp("mtlo_after_reset", FUNCT_MTLO, 32'hCAFE_F00D, 32'h0);
    drive_req(FUNCT_MTLO, 32'hCAFE_F00D, 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    chk("post_reset_busy", 64'(bus.busy), 64'd0);
    pop_and_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
